seg_scan_mux: RTL and testbench

- Time-multiplexed scanner for the 8-digit seven-segment display.
- Sits directly upstream of the hex-to-segment decoder. It holds a 32-bit display word, selects one nibble per scan slot and presents it on nib, which feeds the decoder's 4-bit input.
- Drives the active-low digit anodes and the active-low decimal point.
- Provides tear-free updates, anti-ghosting guard blanking and optional leading-zero suppression.

---
 rtl/seg_scan_mux.sv | 108 ++++++++++
 tb/tb_seg_scan_mux.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_mux.sv
// Time-multiplexed scanner for an 8-digit seven-segment display: slot timing,
// tear-free word swap at frame boundaries, guard blanking and leading-zero suppression.
module seg_scan_mux #(
  parameter int unsigned DIV   = 100000,
  parameter int unsigned GUARD = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data,
  input  logic        load,
  input  logic [7:0]  dp_in,
  input  logic        lzs,
  output logic [7:0]  an,
  output logic [3:0]  nib,
  output logic        dp_n,
  output logic        frame
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CntW-1:0] cnt_q;
  logic [2:0]      idx_q;
  logic [31:0]     act_data_q, pend_data_q;
  logic [7:0]      act_dp_q, pend_dp_q;
  logic            pend_v_q;
  logic            slot_end, boundary;

  logic [7:0]      supp;
  logic            hi_zero;
  logic [7:0]      an_d;
  logic [3:0]      nib_d;
  logic            dp_n_d;

  assign slot_end = (cnt_q == CntW'(DIV - 1));
  assign boundary = slot_end && (idx_q == 3'd7);

  // A digit stays blank only while it and every digit to its left has a zero nibble
  // and an unlit dp, so a lit dp ends the leading-zero run.
  always_comb begin
    supp    = '0;
    hi_zero = 1'b1;
    for (int k = 7; k >= 0; k--) begin
      hi_zero = hi_zero & (act_data_q[4*k +: 4] == 4'h0) & ~act_dp_q[k];
      if (k != 0) supp[k] = lzs & hi_zero;
    end
  end

  always_comb begin
    nib_d  = act_data_q[{idx_q, 2'b00} +: 4];
    dp_n_d = ~act_dp_q[idx_q];
    if ((cnt_q < CntW'(GUARD)) || supp[idx_q]) begin
      an_d = 8'hFF;
    end else begin
      an_d = ~(8'b1 << idx_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (slot_end) begin
      cnt_q <= '0;
      idx_q <= idx_q + 3'd1;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // A load landing on the boundary edge bypasses the pending register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_data_q  <= '0;
      act_dp_q    <= '0;
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      pend_v_q    <= 1'b0;
    end else if (boundary) begin
      if (load) begin
        act_data_q <= data;
        act_dp_q   <= dp_in;
      end else if (pend_v_q) begin
        act_data_q <= pend_data_q;
        act_dp_q   <= pend_dp_q;
      end
      pend_v_q <= 1'b0;
    end else if (load) begin
      pend_data_q <= data;
      pend_dp_q   <= dp_in;
      pend_v_q    <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an    <= 8'hFF;
      nib   <= 4'h0;
      dp_n  <= 1'b1;
      frame <= 1'b0;
    end else begin
      an    <= an_d;
      nib   <= nib_d;
      dp_n  <= dp_n_d;
      frame <= boundary;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux (DIV=8, GUARD=2): directed and random loads checked every cycle
// against a frame-level model of which word is on display.
module tb_seg_scan_mux;

  localparam int unsigned Div   = 8;
  localparam int unsigned Guard = 2;
  localparam int unsigned Frame = 8 * Div;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data = '0;
  logic        load = 1'b0;
  logic [7:0]  dp_in = '0;
  logic        lzs = 1'b0;
  logic [7:0]  an;
  logic [3:0]  nib;
  logic        dp_n;
  logic        frame;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned n = 0;  // edges since reset release

  // Load history: position of the cycle the load was sampled in, and its payload.
  int unsigned lp[$];
  logic [31:0] ld[$];
  logic [7:0]  ldp[$];

  logic [7:0]  exp_an;

  seg_scan_mux #(.DIV(Div), .GUARD(Guard)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .data  (data),
    .load  (load),
    .dp_in (dp_in),
    .lzs   (lzs),
    .an    (an),
    .nib   (nib),
    .dp_n  (dp_n),
    .frame (frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, expv, n);
    end
  endtask

  // Word shown in frame f is the last load sampled in any earlier frame.
  task automatic word_for(input int unsigned f, output logic [31:0] w, output logic [7:0] d);
    w = '0;
    d = '0;
    foreach (lp[i]) begin
      if (lp[i] / Frame < f) begin
        w = ld[i];
        d = ldp[i];
      end
    end
  endtask

  task automatic model(input int unsigned p, output logic [7:0] a, output logic [3:0] nb,
                       output logic dn);
    logic [31:0]  w;
    logic [7:0]   d;
    int unsigned  c, k;
    logic         blank;
    word_for(p / Frame, w, d);
    c  = p % Div;
    k  = (p / Div) % 8;
    nb = 4'((w >> (4 * k)) & 32'hF);
    dn = ~d[k];
    blank = (lzs && k != 0 && (w >> (4 * k)) == 0 && (d >> k) == 0);
    a  = (c < Guard || blank) ? 8'hFF : ~(8'(1) << k);
  endtask

  task automatic tick();
    logic [7:0] ea;
    logic [3:0] en;
    logic       ed;
    @(posedge clk);
    #1;
    n++;
    if (load) begin
      lp.push_back(n - 1);
      ld.push_back(data);
      ldp.push_back(dp_in);
    end
    model(n - 1, ea, en, ed);
    exp_an = ea;
    chk("an", 32'(an), 32'(ea));
    chk("nib", 32'(nib), 32'(en));
    chk("dp_n", 32'(dp_n), 32'(ed));
    chk("frame", 32'(frame), 32'((n % Frame == 0) && n > 0));
    chk("an_onehot", 32'($countones(~an) <= 1), 32'd1);
  endtask

  task automatic run(input int unsigned cyc);
    for (int i = 0; i < int'(cyc); i++) tick();
  endtask

  task automatic pulse(input logic [31:0] w, input logic [7:0] d);
    data  = w;
    dp_in = d;
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  task automatic run_to(input int unsigned target);
    while (n < target) tick();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_an", 32'(an), 32'hFF);
    chk("rst_nib", 32'(nib), 32'h0);
    chk("rst_dp_n", 32'(dp_n), 32'h1);
    chk("rst_frame", 32'(frame), 32'h0);
    rst_n = 1'b1;

    // Idle scan: guard blanking and frame pulses.
    run(2 * Frame + 5);

    // Mid-frame load appears only from the next frame.
    pulse(32'h1234ABCD, 8'h00);
    run_to(4 * Frame + 3);

    // Two loads in one frame; the later one wins.
    pulse(32'h11111111, 8'h00);
    run(10);
    pulse(32'h22222222, 8'h00);
    run_to(6 * Frame - 1);

    // Load on the boundary cycle goes straight to the next frame.
    pulse(32'h0000CAFE, 8'h03);
    run(Frame + 4);

    // Leading-zero suppression, then a dp that ends the zero run.
    lzs = 1'b1;
    pulse(32'h00000050, 8'h00);
    run_to(10 * Frame);
    pulse(32'h00000050, 8'h10);
    run_to(12 * Frame);

    // Random loads and lzs changes over 10 frames.
    for (int i = 0; i < 10 * int'(Frame); i++) begin
      if ($urandom_range(0, 19) == 0) begin
        data  = $urandom() >> (4 * $urandom_range(0, 7));
        dp_in = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
        load  = 1'b1;
      end else begin
        load = 1'b0;
      end
      if ($urandom_range(0, 99) == 0) lzs = ~lzs;
      tick();
    end
    load = 1'b0;

    // Asynchronous reset while digit 3 is lit.
    lzs = 1'b0;
    pulse(32'h87654321, 8'h00);
    while (!((n - 1) % Frame == 3 * Div + 4 && (n - 1) / Frame > (lp[lp.size() - 1] / Frame)))
      tick();
    chk("pre_rst_an", 32'(an), 32'hF7);
    rst_n = 1'b0;
    #1;
    chk("async_an", 32'(an), 32'hFF);
    chk("async_nib", 32'(nib), 32'h0);
    chk("async_dp_n", 32'(dp_n), 32'h1);
    chk("async_frame", 32'(frame), 32'h0);
    @(posedge clk);
    #1;
    lp.delete();
    ld.delete();
    ldp.delete();
    n = 0;
    rst_n = 1'b1;
    run(Frame + 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
